seq_detector_param: RTL
=======================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial sequence detector: next generation of the fixed 4-state Din/Dout FSM.
//  Detects a runtime-loadable PAT_W-bit pattern on a qualified serial input.
//  Supports Mealy or Moore output, overlapping or non-overlapping detection, and a saturating match counter.
//  Sits between a serial front end and status/interrupt logic.
// PARAMETERS
//  PAT_W      4      pattern length in bits, legal 2..16
//  PAT_RESET  4'b1011  pattern value after reset, PAT_W bits
//  CNT_W      8      width of match counter
//  MOORE      0      0 = Mealy (combinational Dout), 1 = Moore (registered Dout)
// PORTS
//  clk          in   1      clock, rising edge
//  Reset        in   1      asynchronous, active-high reset
//  Din          in   1      serial data bit
//  Din_valid    in   1      Din is sampled only when high
//  pat_load     in   1      load pat_in as new pattern (sync)
//  pat_in       in   PAT_W  new pattern; bit PAT_W-1 is matched first, bit 0 last
//  overlap      in   1      1 = overlapping detection, 0 = restart after a match
//  clr_count    in   1      synchronous clear of match_count
//  Dout         out  1      match pulse
//  match_count  out  CNT_W  number of matches, saturates at all ones
//  fill         out  $clog2(PAT_W+1)  valid history bits held, 0..PAT_W
// BEHAVIOUR
//  Reset: pattern=PAT_RESET, hist=0, fill=0, match_count=0, Dout=0 (Moore register and Mealy path).
//  History: hist[PAT_W-1:0] shifts left on each accepted bit (Din_valid=1, pat_load=0), Din enters bit 0.
//   fill increments on each accepted bit and saturates at PAT_W.
//  Match condition m = Din_valid & ~pat_load & (fill >= PAT_W-1) & ({hist[PAT_W-2:0],Din} == pattern).
//  Mealy (MOORE=0): Dout = m, same cycle as the final bit; 0 whenever Din_valid=0.
//  Moore (MOORE=1): Dout <= m on each edge; one-cycle pulse in the cycle after the final bit.
//  On match, overlap=1: hist/fill update normally, so a suffix can seed the next match.
//  On match, overlap=0: hist<=0 and fill<=0 at that edge; the next match needs PAT_W fresh bits.
//  Din_valid=0: hist, fill and count hold. The Moore Dout register loads 0.
//  pat_load=1: pattern<=pat_in, hist<=0, fill<=0 and Moore Dout<=0. Din is ignored that cycle, no match.
//   pat_load has priority over Din_valid.
//  match_count: +1 on each edge where m=1; holds at 2^CNT_W-1 (no wrap).
//   clr_count and m together: clear wins, count=0.
//   clr_count and pat_load may coincide; both take effect.
//  Reset asserted mid-sequence: all state is cleared at once, including a pending Moore pulse.
//   The first bit after release starts with fill=0.
//  overlap may change on any cycle; its value at the matching edge governs.
//  The state is implicit (fill + hist). No encoded FSM, no unreachable states.
//  Latency: Mealy 0 cycles, Moore 1 cycle from the final accepted bit.
// STRUCTURE
//  Package seq_det_pkg: MODE_MEALY/MODE_MOORE constants, function clog2, PAT_W legality check.
//  Sub-module sat_counter #(W): inc, clr (clr priority), q; used for match_count.
//  Top level: pattern register, history shifter, fill counter, match compare, Dout mux/register.
// TESTING
//  1 PAT_W=4, pattern 1011, overlap=1, Mealy; Din 1,0,1,1,0,1,1 (valid every cycle)
//    -> Dout=1 on bits 4 and 7; match_count=2.
//  2 Same stream with overlap=0 -> Dout=1 on bit 4 only; fill=0 after bit 4, then 3 at end; match_count=1.
//  3 MOORE=1, stream 1,0,1,1 with Din_valid=0 gaps after bits 1 and 3 -> Dout high one cycle after bit 4.
//    hist/fill hold through the gaps.
//  4 pat_load of 0110 asserted with Din=1, Din_valid=1 after bits 1,0,1 -> Din ignored, fill=0.
//    Then 0,1,1,0 -> single match.
//  5 CNT_W=2, 5 overlapping matches of 11 (PAT_W=2, Din=1 x6) -> count 1,2,3,3,3.
//    clr_count on the 6th match edge -> count 0.
//  6 Reset pulsed after bits 1,0,1 of 1011, then 1 -> no match, fill=1, all outputs 0 during Reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants and helpers for the serial sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int MODE_MEALY = 0;
    localparam int MODE_MOORE = 1;

    // Ceiling log2, usable in constant expressions for port widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pattern length must be 2..16 bits.
    function automatic bit pat_w_legal(input int w);
        return (w >= 2) && (w <= 16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    localparam logic [W-1:0] c_MAX = '1;
    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_q;

    // Count up on i_inc, stick at all ones, clear has priority.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != c_MAX)) begin
            r_q <= r_q + c_ONE;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Runtime-loadable serial pattern detector with Mealy/Moore
//               output, overlapping/non-overlapping detection and a
//               saturating match counter. State is implicit in hist + fill.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(4'b1011),
    parameter int               CNT_W     = 8,
    parameter int               MOORE     = 0
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         Din,
    input  logic                         Din_valid,
    input  logic                         pat_load,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic                         overlap,
    input  logic                         clr_count,
    output logic                         Dout,
    output logic [CNT_W-1:0]             match_count,
    output logic [clog2(PAT_W+1)-1:0]    fill
);

    localparam int FILL_W = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] c_FILL_THR = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] c_FILL_ONE = FILL_W'(1);

    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W must be in 2..16");
    end

    logic [PAT_W-1:0] r_pattern;
    // Only the newest PAT_W-1 bits are ever compared, so the oldest
    // history bit is not stored.
    logic [PAT_W-2:0] r_hist;
    logic [FILL_W-1:0] r_fill;

    logic [PAT_W-1:0] w_shift;
    logic             w_accept;
    logic             w_match;

    assign w_shift  = {r_hist, Din};
    assign w_accept = Din_valid & ~pat_load;
    assign w_match  = w_accept & (r_fill >= c_FILL_THR) & (w_shift == r_pattern);

    // Pattern register, history shifter and fill counter.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pattern <= PAT_RESET;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (pat_load) begin
            r_pattern <= pat_in;
            r_hist    <= '0;
            r_fill    <= '0;
        end else if (w_accept) begin
            if (w_match && !overlap) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_shift[PAT_W-2:0];
                if (r_fill != c_FILL_MAX) begin
                    r_fill <= r_fill + c_FILL_ONE;
                end
            end
        end
    end

    if (MOORE == MODE_MOORE) begin : g_moore
        logic r_dout;
        // Registered match pulse, one cycle after the final bit.
        always_ff @(posedge clk or posedge Reset) begin
            if (Reset) begin
                r_dout <= 1'b0;
            end else begin
                r_dout <= w_match;
            end
        end
        assign Dout = r_dout;
    end else begin : g_mealy
        assign Dout = w_match;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .Reset (Reset),
        .i_inc (w_match),
        .i_clr (clr_count),
        .o_q   (match_count)
    );

    assign fill = r_fill;

endmodule
`default_nettype wire
